// File: rtl/pe_psum_bitacc_pkg.sv
// pe_psum_bitacc_pkg: shared widths, FSM state type and bit-channel config helper
package pe_psum_bitacc_pkg;
   localparam int DWd         = 16;
   localparam int PEcol       = 4;
   localparam int AccWd       = 32;
   localparam int PConfDWd    = 4;
   localparam int TileConfDWd = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // a bit-channel count of zero behaves as a single channel
   function automatic logic [PConfDWd-1:0] nz_chan(input logic [PConfDWd-1:0] v);
      return (v == '0) ? PConfDWd'(1) : v;
   endfunction
endpackage

// File: rtl/pe_psum_bitacc_if.sv
// pe_psum_bitacc_if: partial-sum input stream and output-pixel stream handshakes
interface pe_psum_bitacc_if;
   import pe_psum_bitacc_pkg::*;
   logic [DWd*PEcol-1:0]   pspix;
   logic                   pspix_valid;
   logic                   pspix_ready;
   logic [AccWd*PEcol-1:0] opix;
   logic                   opix_valid;
   logic                   opix_ready;

   modport slave (
      input  pspix, pspix_valid, opix_ready,
      output pspix_ready, opix, opix_valid
   );

   modport master (
      output pspix, pspix_valid, opix_ready,
      input  pspix_ready, opix, opix_valid
   );
endinterface

// File: rtl/pe_psum_bitacc_lane.sv
// pe_psum_bitacc_lane: one lane's sign-extend, shift, accumulate and optional ReLU (PE_PSUM_RELU_EN)
module pe_psum_bitacc_lane
   import pe_psum_bitacc_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_last,
   input  logic [7:0]       i_shamt,
   input  logic [DWd-1:0]   i_din,
   output logic [AccWd-1:0] o_res
);
   logic [AccWd-1:0] acc_q, acc_d, ext, term, sum;

   assign ext  = {{(AccWd-DWd){i_din[DWd-1]}}, i_din};
   assign term = ext << i_shamt;
   assign sum  = acc_q + term;

`ifdef PE_PSUM_RELU_EN
   assign o_res = sum[AccWd-1] ? '0 : sum;
`else
   assign o_res = sum;
`endif

   // accumulator restarts on a new tile and after each pixel's final beat
   always_comb begin
      acc_d = i_clr ? '0 : i_en ? (i_last ? '0 : sum) : acc_q;
   end

   // accumulator register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) acc_q <= '0;
      else       acc_q <= acc_d;
   end
endmodule

// File: rtl/pe_psum_bitacc.sv
// pe_psum_bitacc: shift-accumulates Xb*Wb bit-channel partial sums per output pixel; ReLU via PE_PSUM_RELU_EN
module pe_psum_bitacc
   import pe_psum_bitacc_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [PConfDWd-1:0]    i_conf_Xb,
   input  logic [PConfDWd-1:0]    i_conf_Wb,
   input  logic [PConfDWd-1:0]    i_conf_Ab,
   input  logic [TileConfDWd-1:0] i_conf_npix,
   pe_psum_bitacc_if.slave        bus,
   output logic                   o_busy,
   output logic                   o_done
);
   state_e                 state_q, state_d;
   logic [PConfDWd-1:0]    xb_q, xb_d, wb_q, wb_d, ab_q, ab_d;
   logic [PConfDWd-1:0]    xi_q, xi_d, wi_q, wi_d;
   logic [TileConfDWd-1:0] npix_q, npix_d, pix_q, pix_d;
   logic [AccWd*PEcol-1:0] opix_q, opix_d, sum_vec;
   logic                   opix_valid_q, opix_valid_d;
   logic                   done_q, done_d;
   logic                   x_last, w_last, last_beat, rdy, fire;
   logic [7:0]             shamt;

   assign x_last    = xi_q == xb_q - 1'b1;
   assign w_last    = wi_q == wb_q - 1'b1;
   assign last_beat = x_last && w_last;
   assign rdy       = state_q == ACC && !(last_beat && opix_valid_q && !bus.opix_ready);
   assign fire      = bus.pspix_valid && rdy;
   assign shamt     = 8'(ab_q) * (8'(xi_q) + 8'(wi_q));

   assign bus.pspix_ready = rdy;
   assign bus.opix        = opix_q;
   assign bus.opix_valid  = opix_valid_q;
   assign o_busy          = state_q != IDLE;
   assign o_done          = done_q | (state_q == DRAIN && opix_valid_q && bus.opix_ready && !i_start);

   genvar k;
   generate
      for (k = 0; k < PEcol; k++) begin : g_lane
         pe_psum_bitacc_lane u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clr   (i_start),
            .i_en    (fire),
            .i_last  (last_beat),
            .i_shamt (shamt),
            .i_din   (bus.pspix[k*DWd +: DWd]),
            .o_res   (sum_vec[k*AccWd +: AccWd])
         );
      end
   endgenerate

   // beat ordering (wi outer, xi inner), output register handshake and tile sequencing; i_start overrides all
   always_comb begin
      state_d      = state_q;
      xb_d         = xb_q;
      wb_d         = wb_q;
      ab_d         = ab_q;
      npix_d       = npix_q;
      xi_d         = xi_q;
      wi_d         = wi_q;
      pix_d        = pix_q;
      opix_d       = opix_q;
      opix_valid_d = opix_valid_q && !bus.opix_ready;
      done_d       = 1'b0;
      if (fire) begin
         xi_d = x_last ? '0 : xi_q + 1'b1;
         if (x_last) wi_d = w_last ? '0 : wi_q + 1'b1;
         if (last_beat) begin
            pix_d        = pix_q + 1'b1;
            opix_d       = sum_vec;
            opix_valid_d = 1'b1;
            if (pix_q == npix_q - 1'b1) state_d = DRAIN;
         end
      end
      if (state_q == DRAIN && opix_valid_q && bus.opix_ready) state_d = IDLE;
      if (i_start) begin
         xb_d         = nz_chan(i_conf_Xb);
         wb_d         = nz_chan(i_conf_Wb);
         ab_d         = i_conf_Ab;
         npix_d       = i_conf_npix;
         xi_d         = '0;
         wi_d         = '0;
         pix_d        = '0;
         opix_d       = '0;
         opix_valid_d = 1'b0;
         state_d      = (i_conf_npix == '0) ? IDLE : ACC;
         done_d       = i_conf_npix == '0 && state_q == IDLE;
      end
   end

   // state, configuration, counters and output register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         xb_q         <= '0;
         wb_q         <= '0;
         ab_q         <= '0;
         npix_q       <= '0;
         xi_q         <= '0;
         wi_q         <= '0;
         pix_q        <= '0;
         opix_q       <= '0;
         opix_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         xb_q         <= xb_d;
         wb_q         <= wb_d;
         ab_q         <= ab_d;
         npix_q       <= npix_d;
         xi_q         <= xi_d;
         wi_q         <= wi_d;
         pix_q        <= pix_d;
         opix_q       <= opix_d;
         opix_valid_q <= opix_valid_d;
         done_q       <= done_d;
      end
   end
endmodule

// File: tb/tb_pe_psum_bitacc.sv
// tb_pe_psum_bitacc: directed-vector bench for pe_psum_bitacc
module tb_pe_psum_bitacc;
   logic         clk, rst, start, busy, done;
   logic [3:0]   cxb, cwb, cab;
   logic [7:0]   cnpix;
   int           total, bad;
   logic [127:0] log_q[$];

   pe_psum_bitacc_if bus();

   pe_psum_bitacc dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_conf_Xb   (cxb),
      .i_conf_Wb   (cwb),
      .i_conf_Ab   (cab),
      .i_conf_npix (cnpix),
      .bus         (bus),
      .o_busy      (busy),
      .o_done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // output handshakes are recorded half a cycle ahead of the edge that completes them
   always @(negedge clk) if (bus.opix_valid && bus.opix_ready) log_q.push_back(bus.opix);

   function automatic logic [63:0] p16(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   function automatic logic [127:0] p32(input int a, input int b, input int c, input int d);
      return {d, c, b, a};
   endfunction

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] xb, input logic [3:0] wb, input logic [3:0] ab, input logic [7:0] np);
      start = 1'b1; cxb = xb; cwb = wb; cab = ab; cnpix = np;
      cyc();
      start = 1'b0; cxb = 4'hf; cwb = 4'hf; cab = 4'hf; cnpix = 8'hff;
   endtask

   task automatic send_beat(input logic [63:0] d);
      int n;
      n = 0;
      bus.pspix = d;
      bus.pspix_valid = 1'b1;
      #1;
      while (!bus.pspix_ready && n < 50) begin
         cyc();
         n++;
      end
      total++;
      if (n >= 50) begin bad++; $display("FAIL beat_timeout ready=%b required=1", bus.pspix_ready); end
      @(posedge clk);
      #1;
      bus.pspix_valid = 1'b0;
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while (busy && n < 50) begin
         cyc();
         n++;
      end
      total++;
      if (busy) begin bad++; $display("FAIL idle_timeout busy=%b required=0", busy); end
   endtask

   task automatic test_reset;
      #2;
      total++; if (bus.opix !== 128'd0 || bus.opix_valid !== 1'b0) begin bad++; $display("FAIL rst_out opix=%h v=%b required 0", bus.opix, bus.opix_valid); end
      total++; if (bus.pspix_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_ctl rdy=%b busy=%b done=%b required 000", bus.pspix_ready, busy, done); end
      @(posedge clk); #1; rst = 1'b0;
      cyc();
   endtask

   task automatic test_single_bit;
      int s;
      s = log_q.size();
      bus.opix_ready = 1'b1;
      do_start(4'd1, 4'd1, 4'd8, 8'd3);
      total++; if (busy !== 1'b1 || bus.pspix_ready !== 1'b1) begin bad++; $display("FAIL t1_acc busy=%b rdy=%b required 11", busy, bus.pspix_ready); end
      for (int i = 0; i < 3; i++) begin
         send_beat(p16(1, -2, 3, -4));
         total++; if (bus.opix_valid !== 1'b1 || bus.opix !== p32(1, -2, 3, -4)) begin bad++; $display("FAIL t1_opix%0d v=%b opix=%h required 1 %h", i, bus.opix_valid, bus.opix, p32(1, -2, 3, -4)); end
         total++; if (done !== (i == 2)) begin bad++; $display("FAIL t1_done%0d done=%b required %b", i, done, i == 2); end
      end
      cyc();
      total++; if (busy !== 1'b0 || done !== 1'b0 || bus.opix_valid !== 1'b0) begin bad++; $display("FAIL t1_end busy=%b done=%b v=%b required 000", busy, done, bus.opix_valid); end
      total++; if (log_q.size() - s !== 3) begin bad++; $display("FAIL t1_count got=%0d required=3", log_q.size() - s); end
   endtask

   task automatic test_multi_bit;
      bus.opix_ready = 1'b1;
      do_start(4'd2, 4'd2, 4'd2, 8'd1);
      for (int i = 0; i < 4; i++) begin
         send_beat(p16(1, 1, 1, 1));
         total++; if (bus.opix_valid !== (i == 3)) begin bad++; $display("FAIL t2_valid%0d v=%b required %b", i, bus.opix_valid, i == 3); end
      end
      total++; if (bus.opix !== p32(25, 25, 25, 25) || done !== 1'b1) begin bad++; $display("FAIL t2_opix opix=%h done=%b required %h 1", bus.opix, done, p32(25, 25, 25, 25)); end
      cyc();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_idle busy=%b required 0", busy); end
   endtask

   task automatic test_backpressure;
      int s;
      s = log_q.size();
      bus.opix_ready = 1'b0;
      do_start(4'd1, 4'd1, 4'd3, 8'd4);
      send_beat(p16(10, 10, 10, 10));
      bus.pspix = p16(20, 20, 20, 20);
      bus.pspix_valid = 1'b1;
      #1;
      total++; if (bus.pspix_ready !== 1'b0) begin bad++; $display("FAIL t3_stall rdy=%b required 0", bus.pspix_ready); end
      repeat (3) begin
         cyc();
         total++; if (bus.pspix_ready !== 1'b0 || bus.opix !== p32(10, 10, 10, 10) || bus.opix_valid !== 1'b1) begin bad++; $display("FAIL t3_hold rdy=%b v=%b opix=%h required 0 1 %h", bus.pspix_ready, bus.opix_valid, bus.opix, p32(10, 10, 10, 10)); end
      end
      bus.opix_ready = 1'b1;
      send_beat(p16(20, 20, 20, 20));
      send_beat(p16(30, 30, 30, 30));
      send_beat(p16(40, 40, 40, 40));
      wait_idle();
      total++; if (log_q.size() - s !== 4) begin bad++; $display("FAIL t3_count got=%0d required=4", log_q.size() - s); end
      for (int i = 0; i < 4 && s + i < log_q.size(); i++) begin
         total++; if (log_q[s+i] !== p32(10*(i+1), 10*(i+1), 10*(i+1), 10*(i+1))) begin bad++; $display("FAIL t3_order%0d got=%h required=%h", i, log_q[s+i], p32(10*(i+1), 10*(i+1), 10*(i+1), 10*(i+1))); end
      end
   endtask

   task automatic test_simultaneous;
      int s;
      s = log_q.size();
      bus.opix_ready = 1'b1;
      do_start(4'd1, 4'd1, 4'd1, 8'd2);
      send_beat(p16(7, -7, 7, -7));
      send_beat(p16(-9, 9, -9, 9));
      total++; if (bus.opix_valid !== 1'b1 || bus.opix !== p32(-9, 9, -9, 9)) begin bad++; $display("FAIL t4_replace v=%b opix=%h required 1 %h", bus.opix_valid, bus.opix, p32(-9, 9, -9, 9)); end
      total++; if (log_q.size() - s !== 1 || log_q[s] !== p32(7, -7, 7, -7)) begin bad++; $display("FAIL t4_once count=%0d required 1 of %h", log_q.size() - s, p32(7, -7, 7, -7)); end
      cyc();
      total++; if (log_q.size() - s !== 2 || busy !== 1'b0) begin bad++; $display("FAIL t4_drain count=%0d busy=%b required 2 0", log_q.size() - s, busy); end
   endtask

   task automatic test_abort_and_zero;
      bus.opix_ready = 1'b0;
      do_start(4'd1, 4'd1, 4'd0, 8'd2);
      send_beat(p16(5, 5, 5, 5));
      do_start(4'd0, 4'd0, 4'd0, 8'd1);
      total++; if (bus.opix_valid !== 1'b0 || bus.opix !== 128'd0 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL abort v=%b opix=%h busy=%b done=%b required 0 0 1 0", bus.opix_valid, bus.opix, busy, done); end
      bus.opix_ready = 1'b1;
      send_beat(p16(3, 3, 3, 3));
      total++; if (bus.opix !== p32(3, 3, 3, 3) || done !== 1'b1) begin bad++; $display("FAIL abort_res opix=%h done=%b required %h 1", bus.opix, done, p32(3, 3, 3, 3)); end
      cyc();
      do_start(4'd1, 4'd1, 4'd1, 8'd0);
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL npix0 done=%b busy=%b required 1 0", done, busy); end
      cyc();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL npix0_pulse done=%b required 0", done); end
   endtask

   task automatic test_mid_reset;
      bus.opix_ready = 1'b0;
      do_start(4'd2, 4'd2, 4'd1, 8'd2);
      for (int i = 0; i < 4; i++) send_beat(p16(1, 1, 1, 1));
      send_beat(p16(100, 100, 100, 100));
      send_beat(p16(100, 100, 100, 100));
      total++; if (bus.opix !== p32(9, 9, 9, 9) || bus.opix_valid !== 1'b1) begin bad++; $display("FAIL t5_pre opix=%h v=%b required %h 1", bus.opix, bus.opix_valid, p32(9, 9, 9, 9)); end
      rst = 1'b1;
      #1;
      total++; if (bus.opix !== 128'd0 || bus.opix_valid !== 1'b0 || busy !== 1'b0 || bus.pspix_ready !== 1'b0) begin bad++; $display("FAIL t5_async opix=%h v=%b busy=%b rdy=%b required 0", bus.opix, bus.opix_valid, busy, bus.pspix_ready); end
      @(posedge clk); #1; rst = 1'b0;
      bus.opix_ready = 1'b1;
      do_start(4'd2, 4'd2, 4'd1, 8'd1);
      for (int i = 0; i < 4; i++) send_beat(p16(1, -1, 2, 0));
      total++; if (bus.opix !== p32(9, -9, 18, 0) || done !== 1'b1) begin bad++; $display("FAIL t5_after opix=%h done=%b required %h 1", bus.opix, done, p32(9, -9, 18, 0)); end
      cyc();
   endtask

   task automatic test_relu;
      logic [127:0] exp;
`ifdef PE_PSUM_RELU_EN
      exp = p32(0, 5, 0, 0);
`else
      exp = p32(-5, 5, 0, -1);
`endif
      bus.opix_ready = 1'b1;
      do_start(4'd1, 4'd1, 4'd4, 8'd1);
      send_beat(p16(-5, 5, 0, -1));
      total++; if (bus.opix !== exp) begin bad++; $display("FAIL relu opix=%h required=%h", bus.opix, exp); end
      cyc();
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; start = 1'b0;
      cxb = '0; cwb = '0; cab = '0; cnpix = '0;
      bus.pspix = '0; bus.pspix_valid = 1'b0; bus.opix_ready = 1'b0;
      test_reset();
      test_single_bit();
      test_multi_bit();
      test_backpressure();
      test_simultaneous();
      test_abort_and_zero();
      test_mid_reset();
      test_relu();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
